// File: rtl/ysyx_22041207_muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: op encodings,
// FSM state codes and a small op-class helper.
package ysyx_22041207_muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/ysyx_22041207_muldiv_step.sv
// One radix-2 iteration: MSB-first shift-add for multiply, restoring
// shift-subtract for divide (remainder lives in acc low half, quotient in opa).
module ysyx_22041207_muldiv_step #(
    parameter int XLEN = 64
) (
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   acc_in,
    input  logic [XLEN-1:0]     opa_in,
    input  logic [XLEN-1:0]     opb,
    output logic [2*XLEN-1:0]   acc_out,
    output logic [XLEN-1:0]     opa_out
);

    logic [2*XLEN-1:0] mul_addend;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     diff;
    logic              ge;

    always_comb begin
        mul_addend = opa_in[XLEN-1] ? {{XLEN{1'b0}}, opb} : '0;
        shifted    = {acc_in[XLEN-1:0], opa_in[XLEN-1]};
        diff       = shifted - {1'b0, opb};
        ge         = (shifted >= {1'b0, opb});
        if (is_div) begin
            acc_out = {{XLEN{1'b0}}, (ge ? diff[XLEN-1:0] : shifted[XLEN-1:0])};
            opa_out = {opa_in[XLEN-2:0], ge};
        end else begin
            acc_out = {acc_in[2*XLEN-2:0], 1'b0} + mul_addend;
            opa_out = {opa_in[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ysyx_22041207_muldiv.sv
// Iterative RV64M multiply/divide unit on unsigned magnitudes with sign fix-up.
// Optional macro YSYX_22041207_MULDIV_FAST_ZERO_EN short-cuts zero operands.
module ysyx_22041207_muldiv
    import ysyx_22041207_muldiv_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res
);

    localparam logic [CNT_W-1:0] N_FULL = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] N_WORD = CNT_W'(32);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        logic [XLEN-1:0] r;
        r       = {XLEN{x[31]}};
        r[31:0] = x;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] x);
        logic [XLEN-1:0] r;
        r       = '0;
        r[31:0] = x;
        return r;
    endfunction

    logic [1:0]        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [XLEN-1:0]   res_reg;
    logic [2:0]        op_reg;
    logic              word_reg, neg_reg, dz_reg;
    logic [2*XLEN-1:0] acc_reg;
    logic [XLEN-1:0]   opa_reg, opb_reg;

    logic              word_eff, is_div, a_signed, b_signed, neg_a, neg_b, res_neg, dz;
    logic [XLEN-1:0]   ext_a, ext_b, mag_a, mag_b, opa_load;
    logic              bypass;
    logic [XLEN-1:0]   fast_res;
    logic [2*XLEN-1:0] acc_step, prod;
    logic [XLEN-1:0]   opa_step, mul_res, div_mag, div_res, raw_res, fix_res;

    assign word_eff  = (XLEN > 32) ? word : 1'b0;
    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign res       = res_reg;

    // Request decode: extend operands, then reduce to magnitudes plus a result sign.
    always_comb begin
        is_div   = op_is_div(op);
        a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        ext_a    = word_eff ? (a_signed ? sext32(a[31:0]) : zext32(a[31:0])) : a;
        ext_b    = word_eff ? (b_signed ? sext32(b[31:0]) : zext32(b[31:0])) : b;
        neg_a    = a_signed & ext_a[XLEN-1];
        neg_b    = b_signed & ext_b[XLEN-1];
        mag_a    = neg_a ? -ext_a : ext_a;
        mag_b    = neg_b ? -ext_b : ext_b;
        res_neg  = (is_div && op[1]) ? neg_a : (neg_a ^ neg_b);
        dz       = is_div && (ext_b == '0);
        // Word operands are parked in the top half so the MSB-first step sees them first.
        opa_load = is_div ? mag_a : mag_b;
        if (word_eff) opa_load = opa_load << 32;
    end

    always_comb begin
        bypass   = 1'b0;
        fast_res = '0;
`ifdef YSYX_22041207_MULDIV_FAST_ZERO_EN
        bypass   = is_div ? (ext_b == '0) : ((ext_a == '0) || (ext_b == '0));
        fast_res = !is_div ? '0 : (op[1] ? ext_a : '1);
        if (word_eff) fast_res = sext32(fast_res[31:0]);
`endif
    end

    ysyx_22041207_muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (op_reg[2]),
        .acc_in  (acc_reg),
        .opa_in  (opa_reg),
        .opb     (opb_reg),
        .acc_out (acc_step),
        .opa_out (opa_step)
    );

    // Sign fix-up and result selection, applied in the final CALC cycle.
    always_comb begin
        prod = neg_reg ? -acc_reg : acc_reg;
        if (word_reg)
            mul_res = (op_reg == OP_MUL) ? zext32(prod[31:0]) : zext32(prod[63:32]);
        else
            mul_res = (op_reg == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        div_mag = op_reg[1] ? acc_reg[XLEN-1:0] : opa_reg;
        div_res = neg_reg ? -div_mag : div_mag;
        if (dz_reg && !op_reg[1]) div_res = '1;
        raw_res = op_reg[2] ? div_res : mul_res;
        fix_res = word_reg ? sext32(raw_res[31:0]) : raw_res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            res_reg   <= '0;
        end else if (flush) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (in_valid) begin
                    op_reg   <= op;
                    word_reg <= word_eff;
                    neg_reg  <= res_neg;
                    dz_reg   <= dz;
                    acc_reg  <= '0;
                    opa_reg  <= opa_load;
                    opb_reg  <= is_div ? mag_b : mag_a;
                    cnt_reg  <= word_eff ? N_WORD : N_FULL;
                    if (bypass) begin
                        res_reg   <= fast_res;
                        state_reg <= ST_DONE;
                    end else begin
                        state_reg <= ST_CALC;
                    end
                end
                // N step cycles, then one fix-up cycle that registers the result.
                ST_CALC: if (cnt_reg != '0) begin
                    acc_reg <= acc_step;
                    opa_reg <= opa_step;
                    cnt_reg <= cnt_reg - CNT_W'(1);
                end else begin
                    res_reg   <= fix_res;
                    state_reg <= ST_DONE;
                end
                ST_DONE: if (out_ready) state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041207_muldiv.sv
// Directed bench for ysyx_22041207_muldiv with an arithmetic reference model
// and a per-cycle output monitor.
module tb_ysyx_22041207_muldiv;
    import ysyx_22041207_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, word, out_valid, out_ready;
    logic [2:0]  op;
    logic [63:0] a, b, res;

    ysyx_22041207_muldiv #(.XLEN(64), .CNT_W(7)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .word(word), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .res(res)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] exp;
        int unsigned acc_cyc;
        int          lat;
        string       name;
    } exp_t;
    exp_t q[$];
    bit   seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Reference: exact 128-bit arithmetic on the extended operands.
    function automatic logic [63:0] model(input logic [2:0] o, input logic w,
                                          input logic [63:0] aa, input logic [63:0] bb);
        logic signed [127:0] sa, sb;
        logic [127:0]        ua, ub, p;
        logic [63:0]         r;
        if (w) begin
            ua = {96'b0, aa[31:0]};          ub = {96'b0, bb[31:0]};
            sa = {{96{aa[31]}}, aa[31:0]};   sb = {{96{bb[31]}}, bb[31:0]};
        end else begin
            ua = {64'b0, aa};                ub = {64'b0, bb};
            sa = {{64{aa[63]}}, aa};         sb = {{64{bb[63]}}, bb};
        end
        p = '0;
        r = '0;
        case (o)
            OP_MUL:    begin p = ua * ub; r = w ? {32'b0, p[31:0]} : p[63:0]; end
            OP_MULH:   begin p = sa * sb; r = w ? {32'b0, p[63:32]} : p[127:64]; end
            OP_MULHSU: begin p = sa * ub; r = w ? {32'b0, p[63:32]} : p[127:64]; end
            OP_MULHU:  begin p = ua * ub; r = w ? {32'b0, p[63:32]} : p[127:64]; end
            OP_DIV:    if (ub == 0) r = '1; else begin p = sa / sb; r = p[63:0]; end
            OP_DIVU:   if (ub == 0) r = '1; else begin p = ua / ub; r = p[63:0]; end
            OP_REM:    if (ub == 0) r = sa[63:0]; else begin p = sa % sb; r = p[63:0]; end
            default:   if (ub == 0) r = ua[63:0]; else begin p = ua % ub; r = p[63:0]; end
        endcase
        if (w) r = {{32{r[31]}}, r[31:0]};
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic w,
                                   input logic [63:0] aa, input logic [63:0] bb);
`ifdef YSYX_22041207_MULDIV_FAST_ZERO_EN
        bit az, bz;
        az = w ? (aa[31:0] == 0) : (aa == 0);
        bz = w ? (bb[31:0] == 0) : (bb == 0);
        if (o[2] ? bz : (az || bz)) return 1;
`endif
        return w ? 33 : 65;
    endfunction

    // Monitor: every cycle with out_valid, compare against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            chk("in_ready_in_done", {63'b0, in_ready}, 64'd0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got res %h required no result", res);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    chk({q[0].name, "_latency"}, 64'(cyc - q[0].acc_cyc), 64'(q[0].lat));
                end
                chk(q[0].name, res, q[0].exp);
                if (out_ready) begin
                    $display("txn %s res=%h", q[0].name, res);
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string name, input logic [2:0] o, input logic w,
                        input logic [63:0] aa, input logic [63:0] bb);
        exp_t e;
        int   t = 0;
        while (!in_ready && t < 300) begin tick(); t++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL %s_accept: got in_ready=0 required 1 within 300 cycles", name);
        end
        op = o; word = w; a = aa; b = bb; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op = 3'($urandom); word = 1'($urandom);
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        e.exp = model(o, w, aa, bb);
        e.acc_cyc = cyc;
        e.lat = exp_lat(o, w, aa, bb);
        e.name = name;
        q.push_back(e);
    endtask

    task automatic issue(input string name, input logic [2:0] o, input logic w,
                         input logic [63:0] aa, input logic [63:0] bb, input int stall);
        int t = 0;
        if (stall > 0) out_ready = 1'b0;
        send(name, o, w, aa, bb);
        if (stall > 0) begin
            while (!out_valid && t < 300) begin tick(); t++; end
            repeat (stall) tick();
            out_ready = 1'b1;
        end
        t = 0;
        while (q.size() != 0 && t < 300) begin tick(); t++; end
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no result required result within 300 cycles", name);
            q.delete();
            seen = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; word = 1'b0; a = '0; b = '0;
        repeat (3) tick();
        chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
        chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
        chk("reset_res", res, 64'd0);
        rst = 1'b0;
        tick();

        // Pin the reference model with hand-computed values.
        chk("model_mul_7_m3", model(OP_MUL, 0, 64'd7, 64'hFFFFFFFFFFFFFFFD), 64'hFFFFFFFFFFFFFFEB);
        chk("model_mulhu_max", model(OP_MULHU, 0, '1, '1), 64'hFFFFFFFFFFFFFFFE);
        chk("model_mulhsu", model(OP_MULHSU, 0, '1, 64'd2), 64'hFFFFFFFFFFFFFFFF);
        chk("model_div_ovf", model(OP_DIV, 0, 64'h8000000000000000, '1), 64'h8000000000000000);
        chk("model_rem_ovf", model(OP_REM, 0, 64'h8000000000000000, '1), 64'd0);
        chk("model_divu_z", model(OP_DIVU, 0, 64'd5, 64'd0), 64'hFFFFFFFFFFFFFFFF);
        chk("model_remu_z", model(OP_REMU, 0, 64'd5, 64'd0), 64'd5);
        chk("model_divw", model(OP_DIV, 1, 64'h00000000FFFFFFF9, 64'd2), 64'hFFFFFFFFFFFFFFFD);
        chk("model_mul_3_4", model(OP_MUL, 0, 64'd3, 64'd4), 64'd12);
        chk("model_lat_mul", 64'(exp_lat(OP_MUL, 0, 64'd7, 64'hFFFFFFFFFFFFFFFD)), 64'd65);
        chk("model_lat_divw", 64'(exp_lat(OP_DIV, 1, 64'h00000000FFFFFFF9, 64'd2)), 64'd33);
`ifdef YSYX_22041207_MULDIV_FAST_ZERO_EN
        chk("model_lat_mul0", 64'(exp_lat(OP_MUL, 0, 64'd0, 64'd9)), 64'd1);
`endif

        issue("mul_7_m3",     OP_MUL,    0, 64'd7, 64'hFFFFFFFFFFFFFFFD, 0);
        issue("mulhu_max",    OP_MULHU,  0, '1, '1, 0);
        issue("mulhsu_m1_2",  OP_MULHSU, 0, '1, 64'd2, 0);
        issue("mulh_m5_3",    OP_MULH,   0, 64'hFFFFFFFFFFFFFFFB, 64'd3, 0);
        issue("mulh_big",     OP_MULH,   0, 64'h4000000000000000, 64'd4, 0);
        issue("mulh_negneg",  OP_MULH,   0, 64'h8000000000000000, 64'h8000000000000000, 0);
        issue("div_ovf",      OP_DIV,    0, 64'h8000000000000000, '1, 0);
        issue("rem_ovf",      OP_REM,    0, 64'h8000000000000000, '1, 0);
        issue("divu_zero",    OP_DIVU,   0, 64'd5, 64'd0, 0);
        issue("remu_zero",    OP_REMU,   0, 64'd5, 64'd0, 0);
        issue("div_zero_neg", OP_DIV,    0, 64'hFFFFFFFFFFFFFFF7, 64'd0, 0);
        issue("rem_zero_neg", OP_REM,    0, 64'hFFFFFFFFFFFFFFF7, 64'd0, 0);
        issue("div_m7_2",     OP_DIV,    0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 0);
        issue("rem_m7_2",     OP_REM,    0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 0);
        issue("divu_big",     OP_DIVU,   0, 64'hFEDCBA9876543210, 64'h0000000012345678, 0);
        issue("divw_m7_2",    OP_DIV,    1, 64'h00000000FFFFFFF9, 64'd2, 0);
        issue("mulw",         OP_MUL,    1, 64'hDEAD00007FFFFFFF, 64'd2, 0);
        issue("mulhu_w",      OP_MULHU,  1, 64'h00000000FFFFFFFF, 64'h12345678FFFFFFFF, 0);
        issue("remuw",        OP_REMU,   1, 64'h1234567880000001, 64'd3, 0);
        issue("remw_zero",    OP_REM,    1, 64'h0000000080000005, 64'hABCD000000000000, 0);
        issue("mul_a0",       OP_MUL,    0, 64'd0, 64'd123, 0);
        issue("div_a0",       OP_DIV,    0, 64'd0, 64'd5, 0);
        issue("stall_divu",   OP_DIVU,   0, 64'd100, 64'd7, 5);
        issue("stall_mul0",   OP_MUL,    0, 64'd0, 64'd9, 5);

        // Flush mid-calculation: result must never appear.
        send("flushed_mul", OP_MUL, 0, 64'd1234, 64'd5678);
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        q.delete();
        seen = 1'b0;
        chk("flush_in_ready", {63'b0, in_ready}, 64'd1);
        chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
        repeat (80) tick();
        issue("mul_3_4_after_flush", OP_MUL, 0, 64'd3, 64'd4, 0);

        // Flush with a simultaneous request in IDLE: request is dropped.
        op = OP_MUL; word = 1'b0; a = 64'd6; b = 64'd7;
        flush = 1'b1; in_valid = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_over_valid_in_ready", {63'b0, in_ready}, 64'd1);
        repeat (70) tick();

        // Reset mid-calculation discards the operation and clears res.
        send("reset_div", OP_DIV, 0, 64'd1000, 64'd7);
        repeat (20) tick();
        rst = 1'b1;
        tick();
        q.delete();
        seen = 1'b0;
        rst = 1'b0;
        chk("midrst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("midrst_res", res, 64'd0);
        repeat (80) tick();
        issue("remu_after_reset", OP_REMU, 0, 64'd1000, 64'd7, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22041207_muldiv.md
YSYX_22041207_MULDIV -- requirements
Module: ysyx_22041207_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand and result width (32 or 64).
REQ-002 SHALL have parameter CNT_W, default 7, iteration counter width (>= clog2(XLEN)+1).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port flush, input, 1, abort any in-flight operation.
REQ-006 SHALL have port in_valid, input, 1, request present.
REQ-007 SHALL have port in_ready, output, 1, unit can accept a request.
REQ-008 SHALL have port op, input, 3, encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-009 SHALL have port word, input, 1, 32-bit W-variant; ignored when XLEN=32.
REQ-010 SHALL have port a, input, XLEN, first operand (rs1).
REQ-011 SHALL have port b, input, XLEN, second operand (rs2).
REQ-012 SHALL have port out_valid, output, 1, result available.
REQ-013 SHALL have port out_ready, input, 1, consumer takes result.
REQ-014 SHALL have port res, output, XLEN, result.

Function
REQ-015 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 SHALL accept a request when in_valid & in_ready, latching op, word, a, b; inputs may change afterwards.
REQ-017 SHALL perform one radix-2 step per CALC cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-018 SHALL iterate N = XLEN cycles, or 32 when word=1, then enter DONE; acceptance-to-out_valid latency is N+1 cycles.
REQ-019 SHALL, for word=1, use a[31:0]/b[31:0] (sign- or zero-extended per op) and sign-extend bit 31 of the 32-bit result to XLEN.
REQ-020 SHALL return MUL low XLEN bits; MULH/MULHSU/MULHU high XLEN bits of the signed*signed / signed*unsigned / unsigned*unsigned 2*XLEN product.
REQ-021 SHALL, on divide by zero, return quotient all ones and remainder equal to dividend.
REQ-022 SHALL, on signed overflow (most-negative / -1), return quotient = most-negative and remainder = 0.
REQ-023 SHALL hold res and out_valid stable in DONE until out_ready=1, then return to IDLE next cycle.
REQ-024 SHALL not accept a new request in the DONE cycle in which out_ready=1 (no same-cycle back-to-back).
REQ-025 SHALL, on flush in any state, enter IDLE next cycle with out_valid=0; flush overrides simultaneous in_valid (request not accepted).
REQ-026 SHALL treat rst as highest priority over flush and all handshakes.

Reset
REQ-027 SHALL, on rst, set state IDLE, in_ready=1, out_valid=0, res=0, counter=0.
REQ-028 SHALL, when rst is asserted mid-CALC or in DONE, discard the operation with no result produced.

Configuration
REQ-029 SHALL support macro YSYX_22041207_MULDIV_FAST_ZERO_EN.
REQ-030 SHALL, with the macro defined, bypass CALC when either multiply operand or the divisor is zero, entering DONE in the cycle after acceptance (latency 1).
REQ-031 SHALL, without the macro, use full latency N+1 for all operands; results are identical in both builds.

Structure
REQ-032 SHALL place op encoding constants and the FSM state constants in shared package file ysyx_22041207_muldiv_pkg.
REQ-033 SHALL place the one-step shift-add/shift-subtract datapath in sub-module ysyx_22041207_muldiv_step; FSM, counter and sign fix-up stay in the top.

Verification
REQ-034 SHALL cover: XLEN=64, MUL a=7 b=-3 -> res=0xFFFFFFFFFFFFFFEB, out_valid exactly 65 cycles after acceptance.
REQ-035 SHALL cover: MULHU a=b=0xFFFFFFFFFFFFFFFF -> res=0xFFFFFFFFFFFFFFFE; MULHSU a=-1 b=2 -> res=0xFFFFFFFFFFFFFFFF.
REQ-036 SHALL cover: DIV a=0x8000000000000000 b=-1 -> res=0x8000000000000000; REM same operands -> 0; DIVU a=5 b=0 -> all ones; REMU a=5 b=0 -> 5.
REQ-037 SHALL cover: word=1 DIV a=0x00000000FFFFFFF9 b=2 -> res=0xFFFFFFFFFFFFFFFD after 33 cycles.
REQ-038 SHALL cover: flush at CALC cycle 10 -> IDLE next cycle, no out_valid; new MUL 3*4 then returns 12.
REQ-039 SHALL cover: out_ready held low 5 cycles in DONE -> res stable, in_ready=0 throughout; with FAST_ZERO_EN, MUL a=0 -> out_valid one cycle after acceptance.
